// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_pkg : shared types and helpers for the memory arbiter        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // Round-robin pick: on a tie the requester that did not win last time wins.
  function automatic logic arb_pick(input logic ireq, input logic dreq, input logic last);
    if (ireq && dreq) begin
      return ~last;
    end else if (dreq) begin
      return REQ_D;
    end else begin
      return REQ_I;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter : up-counter that sticks at all-ones, async clear        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter : round-robin sharing of one memory port between the    |
// |               I-cache fill path and the D-cache fill/writeback path  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          err,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done,
  output logic          busy,
  output logic [CW-1:0] i_grant_cnt,
  output logic [CW-1:0] d_grant_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t         r_state;
  state_t         w_next_state;
  logic           r_id;
  logic           r_wr;
  logic           r_last;
  logic [AW-1:0]  r_addr;
  logic [DW-1:0]  r_wdata;
  logic [TW-1:0]  r_tcnt;
  logic           r_mem_en;
  logic           r_i_done;
  logic           r_d_done;
  logic           r_err;
  logic           r_busy;
  logic [DW-1:0]  r_i_rdata;
  logic [DW-1:0]  r_d_rdata;

  logic           w_any_req;
  logic           w_win;
  logic           w_timeout;
  logic           w_inc_i;
  logic           w_inc_d;
  logic [DW-1:0]  w_resp_data;

  assign w_any_req   = i_req | d_req;
  assign w_win       = arb_pick(i_req, d_req, r_last);
  assign w_timeout   = (r_tcnt == TW'(TIMEOUT));
  assign w_inc_i     = (r_state == ST_IDLE) && w_any_req && (w_win == REQ_I);
  assign w_inc_d     = (r_state == ST_IDLE) && w_any_req && (w_win == REQ_D);
  // Writes and timeouts both hand back zero data.
  assign w_resp_data = (mem_done && !r_wr) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_req) w_next_state = ST_ISSUE;
      ST_ISSUE: w_next_state = ST_WAIT;
      ST_WAIT:  if (mem_done || w_timeout) w_next_state = ST_RESP;
      ST_RESP:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id      <= REQ_I;
      r_wr      <= 1'b0;
      r_last    <= REQ_I;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tcnt    <= '0;
      r_mem_en  <= 1'b0;
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_busy <= (w_next_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_id     <= w_win;
            r_mem_en <= 1'b1;
            if (w_win == REQ_D) begin
              r_addr  <= d_addr;
              r_wr    <= d_wr;
              r_wdata <= d_wdata;
            end else begin
              r_addr  <= i_addr;
              r_wr    <= 1'b0;
              r_wdata <= '0;
            end
          end
        end
        ST_ISSUE: begin
          r_mem_en <= 1'b0;
          r_tcnt   <= '0;
        end
        ST_WAIT: begin
          r_tcnt <= r_tcnt + TW'(1);
          // A completion on the final timeout cycle still counts as success.
          if (mem_done || w_timeout) begin
            r_err <= ~mem_done;
            if (r_id == REQ_D) begin
              r_d_done  <= 1'b1;
              r_d_rdata <= w_resp_data;
            end else begin
              r_i_done  <= 1'b1;
              r_i_rdata <= w_resp_data;
            end
          end
        end
        ST_RESP: begin
          r_i_done  <= 1'b0;
          r_d_done  <= 1'b0;
          r_err     <= 1'b0;
          r_i_rdata <= '0;
          r_d_rdata <= '0;
          r_last    <= r_id;
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.WIDTH(CW)) u_i_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_inc_i),
    .o_count (i_grant_cnt)
  );

  sat_counter #(.WIDTH(CW)) u_d_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_inc_d),
    .o_count (d_grant_cnt)
  );

  assign i_done    = r_i_done;
  assign i_rdata   = r_i_rdata;
  assign d_done    = r_d_done;
  assign d_rdata   = r_d_rdata;
  assign err       = r_err;
  assign mem_en    = r_mem_en;
  assign mem_wr    = r_wr;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter : scoreboard bench with a transaction-level model     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_done;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_wr = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          err;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_done = 1'b0;
  logic          busy;
  logic [CW-1:0] i_grant_cnt;
  logic [CW-1:0] d_grant_cnt;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .err(err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .busy(busy),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  typedef struct {
    logic        id;
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        err;
  } txn_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  txn_t exp_q[$];
  int   lat_q[$];
  int   last_done_cyc = 0;
  int   rnd_start = 0;

  // reference model state
  logic        m_last = 1'b0;
  int          m_icnt = 0;
  int          m_dcnt = 0;
  logic [15:0] ref_mem [logic [15:0]];

  // memory environment knobs
  bit          mem_silent = 1'b0;
  bit          mem_spurious = 1'b0;
  int          mem_lat_fix = 0;
  int          spur_req = 0;
  int          spur_ack = 0;
  logic [15:0] env_mem [logic [15:0]];
  int          mem_cnt = 0;
  logic [15:0] mem_pend = '0;
  bit          prev_en = 1'b0;

  // per-round request lists
  logic [15:0] ri_addr [4];
  logic [15:0] rd_addr [4];
  logic        rd_wr   [4];
  logic [15:0] rd_wdata[4];

  always @(posedge clk) cyc++;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void predict(input logic id, input logic [15:0] addr, input logic wr,
                                  input logic [15:0] wdata);
    txn_t t;
    t.id = id; t.addr = addr; t.wr = wr; t.wdata = wdata; t.err = mem_silent;
    if (mem_silent) begin
      t.rdata = 16'h0;
    end else if (wr) begin
      ref_mem[addr] = wdata;
      t.rdata = 16'h0;
    end else begin
      t.rdata = ref_mem.exists(addr) ? ref_mem[addr] : 16'h0;
    end
    exp_q.push_back(t);
    if (id) m_dcnt++; else m_icnt++;
    m_last = id;
  endfunction

  // Memory environment: responds L cycles after the command strobe.
  always @(negedge clk) begin
    int L;
    mem_done = 1'b0;
    mem_rdata = '0;
    if (!rst_n) begin
      mem_cnt = 0;
      prev_en = 1'b0;
    end else begin
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          mem_done = 1'b1;
          mem_rdata = mem_pend;
        end
      end
      if (spur_req != spur_ack) begin
        spur_ack = spur_req;
        mem_done = 1'b1;
        mem_rdata = 16'h5A5A;
      end
      if (mem_en) begin
        check("mem_en_one_cycle", {31'b0, prev_en}, 32'd0);
        if (exp_q.size() == 0) begin
          check("mem_en_unexpected", 32'd1, 32'd0);
        end else begin
          check("mem_addr", {16'b0, mem_addr}, {16'b0, exp_q[0].addr});
          check("mem_wr", {31'b0, mem_wr}, {31'b0, exp_q[0].wr});
          if (exp_q[0].wr) check("mem_wdata", {16'b0, mem_wdata}, {16'b0, exp_q[0].wdata});
        end
        if (mem_silent) begin
          lat_q.push_back(cyc + TO + 2);
        end else begin
          L = (mem_lat_fix != 0) ? mem_lat_fix : int'($urandom_range(1, 4));
          if (mem_spurious && L < 2) L = 2;
          mem_cnt = L;
          if (mem_wr) begin
            env_mem[mem_addr] = mem_wdata;
            mem_pend = 16'($urandom);
          end else begin
            mem_pend = env_mem.exists(mem_addr) ? env_mem[mem_addr] : 16'h0;
          end
          lat_q.push_back(cyc + L + 1);
          if (mem_spurious) begin
            mem_done = 1'b1;
            mem_rdata = 16'hDEAD;
          end
        end
      end
      prev_en = mem_en;
    end
  end

  // Monitor: pops the scoreboard whenever a done pulse appears.
  always @(negedge clk) begin
    txn_t e;
    if (!rst_n) begin
      exp_q.delete();
      lat_q.delete();
    end else if (i_done && d_done) begin
      check("both_done", 32'd1, 32'd0);
    end else if (i_done || d_done) begin
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_id", {31'b0, d_done}, {31'b0, e.id});
        check("rdata", {16'b0, (d_done ? d_rdata : i_rdata)}, {16'b0, e.rdata});
        check("err", {31'b0, err}, {31'b0, e.err});
        if (lat_q.size() > 0) check("done_cycle", cyc, lat_q.pop_front());
      end
    end else if (err) begin
      check("err_without_done", 32'd1, 32'd0);
    end
  end

  task automatic rand_lists();
    for (int k = 0; k < 4; k++) begin
      ri_addr[k]  = 16'h0100 + 16'($urandom_range(0, 7));
      rd_addr[k]  = 16'h0100 + 16'($urandom_range(0, 7));
      rd_wr[k]    = 1'($urandom_range(0, 1));
      rd_wdata[k] = 16'($urandom);
    end
  endtask

  // Each requester holds req until its ni/nd transactions are done.
  task automatic run_round(input int ni, input int nd);
    int qi = 0, qd = 0, pi = 0, pd = 0, budget;
    logic w;
    while (qi < ni || qd < nd) begin
      if (qi < ni && qd < nd) w = ~m_last;
      else w = (qd < nd);
      if (w) begin
        predict(1'b1, rd_addr[qd], rd_wr[qd], rd_wdata[qd]); qd++;
      end else begin
        predict(1'b0, ri_addr[qi], 1'b0, 16'h0); qi++;
      end
    end
    budget = (ni + nd) * (TO + 20);
    @(negedge clk);
    rnd_start = cyc;
    if (ni > 0) begin i_req = 1'b1; i_addr = ri_addr[0]; end
    if (nd > 0) begin
      d_req = 1'b1; d_addr = rd_addr[0]; d_wr = rd_wr[0]; d_wdata = rd_wdata[0];
    end
    for (int c = 0; c < budget && (pi < ni || pd < nd); c++) begin
      @(negedge clk);
      if (i_done && pi < ni) begin
        pi++;
        if (pi < ni) i_addr = ri_addr[pi]; else i_req = 1'b0;
      end
      if (d_done && pd < nd) begin
        pd++;
        if (pd < nd) begin
          d_addr = rd_addr[pd]; d_wr = rd_wr[pd]; d_wdata = rd_wdata[pd];
        end else begin
          d_req = 1'b0;
        end
      end
    end
    check("round_completed", pi + pd, ni + nd);
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("i_grant_cnt", {16'b0, i_grant_cnt}, m_icnt);
    check("d_grant_cnt", {16'b0, d_grant_cnt}, m_dcnt);
    check("busy_after_round", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_mem_en", {31'b0, mem_en}, 32'd0);
    check("rst_done", {30'b0, i_done, d_done}, 32'd0);
    check("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
    check("rst_cnts", {i_grant_cnt, d_grant_cnt}, 32'd0);
    rst_n = 1'b1;

    // Simultaneous requests from reset, both held: D, I, D.
    rand_lists();
    run_round(1, 2);

    // Single I read with one-cycle memory latency.
    env_mem[16'h0040] = 16'hBEEF;
    ref_mem[16'h0040] = 16'hBEEF;
    mem_lat_fix = 1;
    ri_addr[0] = 16'h0040;
    run_round(1, 0);
    check("i_read_latency", last_done_cyc, rnd_start + 3);

    // D write.
    rd_addr[0] = 16'h1234; rd_wr[0] = 1'b1; rd_wdata[0] = 16'hA5A5;
    run_round(0, 1);
    mem_lat_fix = 0;

    // Timeout, then a normal transaction.
    mem_silent = 1'b1;
    ri_addr[0] = 16'h0040;
    run_round(1, 0);
    mem_silent = 1'b0;
    rd_addr[0] = 16'h1234; rd_wr[0] = 1'b0;
    run_round(0, 1);

    // Reset asserted while waiting on memory.
    mem_silent = 1'b1;
    predict(1'b1, 16'h0077, 1'b0, 16'h0);
    @(negedge clk);
    d_req = 1'b1; d_addr = 16'h0077; d_wr = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_mem_en", {31'b0, mem_en}, 32'd0);
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    check("async_rst_cnts", {i_grant_cnt, d_grant_cnt}, 32'd0);
    check("async_rst_done", {29'b0, i_done, d_done, err}, 32'd0);
    d_req = 1'b0;
    m_last = 1'b0; m_icnt = 0; m_dcnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mem_silent = 1'b0;
    rand_lists();
    run_round(1, 1);

    // Spurious completion in IDLE, then in ISSUE.
    spur_req++;
    repeat (3) @(negedge clk);
    check("spur_idle_busy", {31'b0, busy}, 32'd0);
    mem_spurious = 1'b1;
    rand_lists();
    run_round(1, 1);
    mem_spurious = 1'b0;

    for (int r = 0; r < 40; r++) begin
      int ni, nd;
      ni = int'($urandom_range(0, 2));
      nd = int'($urandom_range(0, 2));
      if (ni == 0 && nd == 0) nd = 1;
      rand_lists();
      mem_spurious = ($urandom_range(0, 4) == 0);
      run_round(ni, nd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
